// File: rtl/gate_response_checker.sv
`timescale 1ns/1ps
// ----------------------------------------------------------------------------
// gate_response_checker
//
// Response end of the two-input gate interface. A start pulse walks the a/b
// stimulus pair through 00, 01, 10, 11. Each vector is held for SETTLE_CYCLES
// cycles and then sampled for one cycle, where the seven gate responses are
// compared against golden values.
//
// Parameters
//   SETTLE_CYCLES  cycles spent in SETTLE per vector (>= 1)
//
// Ports
//   clk            rising-edge clock
//   rst_n          synchronous active-low reset
//   start          single-cycle run request, honoured in IDLE or DONE only
//   a, b           registered stimulus (vector bit 1, bit 0)
//   and_y..xnor_y  responses from the gate block under test
//   busy           high in SETTLE or SAMPLE
//   done           high in DONE, held until the next accepted start
//   pass           high in DONE when no vector failed
//   err_count      number of failing vectors (0..4)
//   fail_mask      sticky per-output failure flags
//                  {xnor, xor, nor, nand, not, or, and}
//   first_fail_vec {a,b} of the first failing vector, 0 if none
// ----------------------------------------------------------------------------
module gate_response_checker #(
   parameter int unsigned SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   output logic       a,
   output logic       b,
   input  logic       and_y,
   input  logic       or_y,
   input  logic       not_y,
   input  logic       nand_y,
   input  logic       nor_y,
   input  logic       xor_y,
   input  logic       xnor_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [2:0] err_count,
   output logic [6:0] fail_mask,
   output logic [1:0] first_fail_vec
);

   if (SETTLE_CYCLES < 1) begin : g_bad_settle
      $error("gate_response_checker: SETTLE_CYCLES must be at least 1");
   end

   localparam int unsigned CNT_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);
   localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      SAMPLE = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t           state_q;
   logic [1:0]       vec_q;
   logic [CNT_W-1:0] settle_q;
   logic             busy_q;
   logic             done_q;
   logic             pass_q;
   logic [2:0]       err_count_q;
   logic [6:0]       fail_mask_q;
   logic [1:0]       first_fail_q;

   logic [6:0]       golden;
   logic [6:0]       mismatch;
   logic             any_fail;

   // Golden responses for the vector currently on a/b.
   always_comb begin
      golden    = '0;
      golden[0] = vec_q[1] & vec_q[0];
      golden[1] = vec_q[1] | vec_q[0];
      golden[2] = ~vec_q[1];
      golden[3] = ~(vec_q[1] & vec_q[0]);
      golden[4] = ~(vec_q[1] | vec_q[0]);
      golden[5] = vec_q[1] ^ vec_q[0];
      golden[6] = ~(vec_q[1] ^ vec_q[0]);
      mismatch  = {xnor_y, xor_y, nor_y, nand_y, not_y, or_y, and_y} ^ golden;
      any_fail  = |mismatch;
   end

   // NOTE: all state lives in this one clocked block with non-blocking
   // assignments; the reset branch is synchronous, so it sits inside the
   // clocked block and is not in the sensitivity list.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         vec_q        <= '0;
         settle_q     <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         pass_q       <= 1'b0;
         err_count_q  <= '0;
         fail_mask_q  <= '0;
         first_fail_q <= '0;
      end else begin
         case (state_q)
            IDLE, DONE: begin
               if (start) begin
                  state_q      <= SETTLE;
                  vec_q        <= '0;
                  settle_q     <= SETTLE_LOAD;
                  busy_q       <= 1'b1;
                  done_q       <= 1'b0;
                  pass_q       <= 1'b0;
                  err_count_q  <= '0;
                  fail_mask_q  <= '0;
                  first_fail_q <= '0;
               end
            end
            SETTLE: begin
               settle_q <= settle_q - CNT_W'(1);
               // Leave as the counter steps to zero, so each vector spends
               // exactly SETTLE_CYCLES edges here.
               if (settle_q == CNT_W'(1)) begin
                  state_q <= SAMPLE;
               end
            end
            SAMPLE: begin
               fail_mask_q <= fail_mask_q | mismatch;
               if (any_fail) begin
                  err_count_q <= err_count_q + 3'd1;
                  // A zero count means no earlier vector has failed.
                  if (err_count_q == 3'd0) begin
                     first_fail_q <= vec_q;
                  end
               end
               if (vec_q == 2'b11) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  pass_q  <= (err_count_q == 3'd0) && !any_fail;
               end else begin
                  state_q  <= SETTLE;
                  vec_q    <= vec_q + 2'd1;
                  settle_q <= SETTLE_LOAD;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign a              = vec_q[1];
   assign b              = vec_q[0];
   assign busy           = busy_q;
   assign done           = done_q;
   assign pass           = pass_q;
   assign err_count      = err_count_q;
   assign fail_mask      = fail_mask_q;
   assign first_fail_vec = first_fail_q;

endmodule

// File: tb/tb_gate_response_checker.sv
`timescale 1ns/1ps
module tb_gate_response_checker;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst_n;
   int   fault;

   // Instance 0: SETTLE_CYCLES = 2 with a fault-injectable gate model.
   logic       start, a, b, busy, done, pass;
   logic       and_y, or_y, not_y, nand_y, nor_y, xor_y, xnor_y;
   logic [2:0] err_count;
   logic [6:0] fail_mask;
   logic [1:0] first_fail_vec;

   // fault 1: xor_y stuck at 0; fault 2: not_y wired to a.
   assign and_y  = a & b;
   assign or_y   = a | b;
   assign not_y  = (fault == 2) ? a : ~a;
   assign nand_y = ~(a & b);
   assign nor_y  = ~(a | b);
   assign xor_y  = (fault == 1) ? 1'b0 : (a ^ b);
   assign xnor_y = ~(a ^ b);

   gate_response_checker #(.SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
      .and_y(and_y), .or_y(or_y), .not_y(not_y), .nand_y(nand_y),
      .nor_y(nor_y), .xor_y(xor_y), .xnor_y(xnor_y),
      .busy(busy), .done(done), .pass(pass), .err_count(err_count),
      .fail_mask(fail_mask), .first_fail_vec(first_fail_vec)
   );

   // Instance 1: SETTLE_CYCLES = 1 with a correct gate model.
   logic       start1, a1, b1, busy1, done1, pass1;
   logic [2:0] err_count1;
   logic [6:0] fail_mask1;
   logic [1:0] first_fail_vec1;

   gate_response_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .a(a1), .b(b1),
      .and_y(a1 & b1), .or_y(a1 | b1), .not_y(~a1), .nand_y(~(a1 & b1)),
      .nor_y(~(a1 | b1)), .xor_y(a1 ^ b1), .xnor_y(~(a1 ^ b1)),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1),
      .fail_mask(fail_mask1), .first_fail_vec(first_fail_vec1)
   );

   int unsigned n_pass  = 0;
   int unsigned n_total = 0;

   task automatic test_reset();
      rst_n  = 1'b0;
      start  = 1'b0;
      start1 = 1'b0;
      fault  = 0;
      repeat (3) @(posedge clk);
      #1;
      n_total++;
      if ({a, b, busy, done, pass, err_count, fail_mask, first_fail_vec} !== 17'd0) begin
         $display("FAIL reset_s2: got a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%b, want all 0",
                  a, b, busy, done, pass, err_count, fail_mask, first_fail_vec);
      end else n_pass++;
      n_total++;
      if ({a1, b1, busy1, done1, pass1, err_count1, fail_mask1, first_fail_vec1} !== 17'd0) begin
         $display("FAIL reset_s1: got a=%b b=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%b, want all 0",
                  a1, b1, busy1, done1, pass1, err_count1, fail_mask1, first_fail_vec1);
      end else n_pass++;
      rst_n = 1'b1;
   endtask

   // Full sequence on instance 0. extra_edge != 0 pulses start again so that
   // it is sampled at that edge (must be ignored while busy).
   task automatic run_seq(input string name, input int extra_edge,
                          input logic [2:0] exp_err, input logic [6:0] exp_mask,
                          input logic [1:0] exp_ffv, input logic exp_pass);
      logic [1:0] exp_ab;
      logic       exp_busy, exp_done;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);                       // edge 0
      #1 start = 1'b0;
      n_total++;
      if ({a, b} !== 2'b00 || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0 ||
          err_count !== 3'd0 || fail_mask !== 7'd0 || first_fail_vec !== 2'd0) begin
         $display("FAIL %s_edge0: got ab=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%b, want ab=00 busy=1 rest 0",
                  name, {a, b}, busy, done, pass, err_count, fail_mask, first_fail_vec);
      end else n_pass++;
      for (int e = 1; e <= 13; e++) begin
         if (e == extra_edge) start = 1'b1;
         @(posedge clk);
         #1 start = 1'b0;
         exp_ab   = (e / 3 > 3) ? 2'd3 : 2'(e / 3);
         exp_busy = (e < 12);
         exp_done = (e >= 12);
         n_total++;
         if ({a, b} !== exp_ab || busy !== exp_busy || done !== exp_done) begin
            $display("FAIL %s_edge%0d: got ab=%b busy=%b done=%b, want ab=%b busy=%b done=%b",
                     name, e, {a, b}, busy, done, exp_ab, exp_busy, exp_done);
         end else n_pass++;
      end
      n_total++;
      if (err_count !== exp_err || fail_mask !== exp_mask ||
          first_fail_vec !== exp_ffv || pass !== exp_pass) begin
         $display("FAIL %s_result: got err=%0d mask=%b ffv=%b pass=%b, want err=%0d mask=%b ffv=%b pass=%b",
                  name, err_count, fail_mask, first_fail_vec, pass,
                  exp_err, exp_mask, exp_ffv, exp_pass);
      end else n_pass++;
   endtask

   task automatic test_correct();
      fault = 0;
      run_seq("correct", 0, 3'd0, 7'b0000000, 2'b00, 1'b1);
   endtask

   task automatic test_xor_stuck();
      fault = 1;
      run_seq("xor_stuck", 0, 3'd2, 7'b0100000, 2'b01, 1'b0);
   endtask

   task automatic test_not_fault();
      fault = 2;
      run_seq("not_fault", 0, 3'd4, 7'b0000100, 2'b00, 1'b0);
   endtask

   // Starts from DONE with err=4 left over, so edge-0 clearing is exercised.
   task automatic test_back_to_back();
      fault = 0;
      run_seq("busy_start", 4, 3'd0, 7'b0000000, 2'b00, 1'b1);
      fault = 1;
      run_seq("restart_xor", 0, 3'd2, 7'b0100000, 2'b01, 1'b0);
   endtask

   task automatic test_reset_mid();
      fault = 0;
      @(negedge clk);
      start = 1'b1;
      @(posedge clk);                       // edge 0
      #1 start = 1'b0;
      repeat (6) @(posedge clk);            // edge 6: vector 10 enters SETTLE
      #1;
      n_total++;
      if ({a, b} !== 2'b10 || busy !== 1'b1) begin
         $display("FAIL mid_pre: got ab=%b busy=%b, want ab=10 busy=1", {a, b}, busy);
      end else n_pass++;
      rst_n = 1'b0;
      @(posedge clk);                       // edge 7, reset sampled
      #1 rst_n = 1'b1;
      n_total++;
      if ({a, b, busy, done, pass, err_count, fail_mask, first_fail_vec} !== 17'd0) begin
         $display("FAIL mid_reset: got ab=%b busy=%b done=%b pass=%b err=%0d mask=%b ffv=%b, want all 0",
                  {a, b}, busy, done, pass, err_count, fail_mask, first_fail_vec);
      end else n_pass++;
      repeat (4) @(posedge clk);
      #1;
      n_total++;
      if ({a, b} !== 2'b00 || busy !== 1'b0 || done !== 1'b0) begin
         $display("FAIL mid_idle: got ab=%b busy=%b done=%b, want 00 0 0", {a, b}, busy, done);
      end else n_pass++;
      run_seq("after_reset", 0, 3'd0, 7'b0000000, 2'b00, 1'b1);
   endtask

   task automatic test_settle_sweep();
      logic [1:0] exp_ab;
      logic       exp_busy, exp_done;
      @(negedge clk);
      start1 = 1'b1;
      @(posedge clk);                       // edge 0
      #1 start1 = 1'b0;
      for (int e = 1; e <= 9; e++) begin
         @(posedge clk);
         #1;
         exp_ab   = (e / 2 > 3) ? 2'd3 : 2'(e / 2);
         exp_busy = (e < 8);
         exp_done = (e >= 8);
         n_total++;
         if ({a1, b1} !== exp_ab || busy1 !== exp_busy || done1 !== exp_done) begin
            $display("FAIL sweep_edge%0d: got ab=%b busy=%b done=%b, want ab=%b busy=%b done=%b",
                     e, {a1, b1}, busy1, done1, exp_ab, exp_busy, exp_done);
         end else n_pass++;
      end
      n_total++;
      if (pass1 !== 1'b1 || err_count1 !== 3'd0 || fail_mask1 !== 7'd0) begin
         $display("FAIL sweep_result: got pass=%b err=%0d mask=%b, want 1 0 0000000",
                  pass1, err_count1, fail_mask1);
      end else n_pass++;
   endtask

   initial begin
      test_reset();
      test_correct();
      test_xor_stuck();
      test_not_fault();
      test_back_to_back();
      test_reset_mid();
      test_settle_sweep();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
